// File: rtl/decoder_pkg.sv
// Shared types and round-robin pick helper for the 8-way decoder arbiter.
package decoder_pkg;

   typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   // First set bit of req, scanning from last+1 upward with wrap-around.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   last);
      logic [2*NUM_REQ-1:0] dbl;
      logic [NUM_REQ-1:0]   rot;
      logic [IDX_W-1:0]     off;
      dbl = {req, req};
      rot = NUM_REQ'(dbl >> ({1'b0, last} + 4'd1));
      off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) off = IDX_W'(k);
      end
      return IDX_W'(last + 3'd1 + off);
   endfunction

endpackage

// File: rtl/rr_priority_pick8.sv
// Combinational rotate-and-priority-encode picker for eight requesters.
module rr_priority_pick8
   import decoder_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_valid
);

   assign o_idx   = rr_pick(i_req, i_last);
   assign o_valid = |i_req;

endmodule

// File: rtl/decoder_arbiter_8.sv
// Round-robin arbiter sharing one 3-to-8 decoder; break-before-make with
// a bounded hold time per grant.
module decoder_arbiter_8
   import decoder_pkg::*;
#(
   parameter int MAX_HOLD = 15,
   parameter int CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic               sel_a,
   output logic               sel_b,
   output logic               sel_c,
   output logic               dec_en,
   output logic [NUM_REQ-1:0] grant,
   output logic               timeout
);

   state_t             r_state;
   logic [IDX_W-1:0]   r_last;
   logic [IDX_W-1:0]   r_sel;
   logic               r_dec_en;
   logic [NUM_REQ-1:0] r_grant;
   logic               r_timeout;
   logic [CNT_W-1:0]   r_hold;

   logic [IDX_W-1:0]   w_pick_idx;
   logic               w_pick_vld;

   rr_priority_pick8 u_pick (
      .i_req   (req),
      .i_last  (r_last),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_vld)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_last    <= 3'd7;
         r_sel     <= '0;
         r_dec_en  <= 1'b0;
         r_grant   <= '0;
         r_timeout <= 1'b0;
         r_hold    <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pick_vld) begin
                  r_sel    <= w_pick_idx;
                  r_dec_en <= 1'b1;
                  r_grant  <= NUM_REQ'(1) << w_pick_idx;
                  r_hold   <= CNT_W'(1);
                  r_state  <= GRANT;
               end
            end
            GRANT: begin
               // A dropped request wins over expiry, so no timeout pulse then.
               if (!req[r_sel]) begin
                  r_dec_en <= 1'b0;
                  r_grant  <= '0;
                  r_last   <= r_sel;
                  r_state  <= IDLE;
               end else if (r_hold == CNT_W'(MAX_HOLD)) begin
                  r_dec_en  <= 1'b0;
                  r_grant   <= '0;
                  r_last    <= r_sel;
                  r_timeout <= 1'b1;
                  r_state   <= IDLE;
               end else begin
                  r_hold <= r_hold + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign sel_a   = r_sel[2];
   assign sel_b   = r_sel[1];
   assign sel_c   = r_sel[0];
   assign dec_en  = r_dec_en;
   assign grant   = r_grant;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_decoder_arbiter_8.sv
// Randomized and directed check of decoder_arbiter_8 at three hold limits
// against a cycle-level reference model.
module tb_decoder_arbiter_8;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'hFF;

   logic       sa [NI];
   logic       sb [NI];
   logic       sc [NI];
   logic       en [NI];
   logic       to [NI];
   logic [7:0] gr [NI];

   int         mh [NI] = '{2, 3, 15};

   // reference model state
   bit         m_on   [NI];
   logic [2:0] m_sel  [NI];
   logic [2:0] m_last [NI];
   int         m_hold [NI];
   bit         m_to   [NI];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decoder_arbiter_8 #(.MAX_HOLD(2), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req(req), .sel_a(sa[0]), .sel_b(sb[0]),
      .sel_c(sc[0]), .dec_en(en[0]), .grant(gr[0]), .timeout(to[0]));
   decoder_arbiter_8 #(.MAX_HOLD(3), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .sel_a(sa[1]), .sel_b(sb[1]),
      .sel_c(sc[1]), .dec_en(en[1]), .grant(gr[1]), .timeout(to[1]));
   decoder_arbiter_8 #(.MAX_HOLD(15), .CNT_W(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req(req), .sel_a(sa[2]), .sel_b(sb[2]),
      .sel_c(sc[2]), .dec_en(en[2]), .grant(gr[2]), .timeout(to[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input int k, input logic r, input logic [7:0] q);
      int j;
      if (!r) begin
         m_on[k] = 0; m_sel[k] = 3'd0; m_last[k] = 3'd7; m_hold[k] = 0; m_to[k] = 0;
      end else if (!m_on[k]) begin
         m_to[k] = 0;
         for (int off = 1; off <= 8; off++) begin
            j = (int'(m_last[k]) + off) % 8;
            if (q[j] && !m_on[k]) begin
               m_on[k] = 1; m_sel[k] = 3'(j); m_hold[k] = 1;
            end
         end
      end else if (!q[m_sel[k]]) begin
         m_on[k] = 0; m_last[k] = m_sel[k]; m_to[k] = 0;
      end else if (m_hold[k] == mh[k]) begin
         m_on[k] = 0; m_last[k] = m_sel[k]; m_to[k] = 1;
      end else begin
         m_hold[k]++;
      end
   endtask

   task automatic step(input logic r, input logic [7:0] q);
      @(negedge clk);
      rst_n = r;
      req   = q;
      @(posedge clk);
      for (int k = 0; k < NI; k++) model_step(k, r, q);
      #1;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("i%0d_en_sel_to", k), {27'd0, en[k], sa[k], sb[k], sc[k], to[k]},
             {27'd0, m_on[k], m_sel[k], m_to[k]});
         chk($sformatf("i%0d_grant", k), {24'd0, gr[k]},
             {24'd0, m_on[k] ? (8'd1 << m_sel[k]) : 8'd0});
      end
   endtask

   initial begin
      logic [7:0] q;
      // reset with every requester asserted, then first grant to 0
      step(1'b0, 8'hFF);
      step(1'b0, 8'hFF);
      chk("rst_grant", {24'd0, gr[2]}, 32'd0);
      chk("rst_en", {31'd0, en[2]}, 32'd0);
      step(1'b1, 8'hFF);
      chk("rst_rel_grant", {24'd0, gr[2]}, 32'h01);

      // single requester holds then releases
      step(1'b0, 8'h00);
      for (int i = 0; i < 4; i++) step(1'b1, 8'h20);
      chk("single_sel", {29'd0, sa[2], sb[2], sc[2]}, 32'd5);
      for (int i = 0; i < 3; i++) step(1'b1, 8'h00);
      chk("single_no_to", {31'd0, to[2]}, 32'd0);

      // full rotation under continuous request
      step(1'b0, 8'h00);
      for (int i = 0; i < 30; i++) step(1'b1, 8'hFF);

      // lone requester re-granted after each expiry
      step(1'b0, 8'h00);
      for (int i = 0; i < 10; i++) step(1'b1, 8'h04);

      // release on the same edge as expiry
      step(1'b0, 8'h00);
      for (int i = 0; i < 3; i++) step(1'b1, 8'h04);
      step(1'b1, 8'h00);
      chk("tie_to", {31'd0, to[1]}, 32'd0);
      step(1'b1, 8'h0C);
      chk("tie_next", {24'd0, gr[1]}, 32'h08);

      // reset in mid-grant clears the pointer
      step(1'b0, 8'h00);
      step(1'b1, 8'h10);
      chk("mid_grant", {24'd0, gr[2]}, 32'h10);
      step(1'b0, 8'h10);
      chk("mid_rst_grant", {24'd0, gr[2]}, 32'd0);
      step(1'b1, 8'h11);
      chk("mid_rst_ptr", {24'd0, gr[2]}, 32'h01);

      // random traffic with occasional reset
      q = 8'h00;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(3) == 0) begin
            case ($urandom_range(3))
               0: q = 8'h00;
               1: q = 8'd1 << $urandom_range(7);
               2: q = 8'hFF;
               default: q = 8'($urandom);
            endcase
         end
         step(($urandom_range(99) == 0) ? 1'b0 : 1'b1, q);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
